// File: rtl/mem_arbiter_if.sv
// Memory arbiter bus bundle: IF and LS request ports plus the shared memory port.
// The arbiter takes the slave view; the front ends and memory model take the master view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req;
    logic        ls_wren;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        bus_err;
    logic        mem_req;
    logic        mem_wren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        owner;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wren, ls_addr, ls_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_ack, ls_rdata, ls_ack, bus_err,
        output mem_req, mem_wren, mem_addr, mem_wdata, owner
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wren, ls_addr, ls_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_ack, ls_rdata, ls_ack, bus_err,
        input  mem_req, mem_wren, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS).
// LS has priority, bounded by a streak limit so IF cannot starve; stuck accesses time out.
module mem_arbiter #(
    parameter int MAX_LS_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SMAX = SW'(MAX_LS_STREAK);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          owner_q, owner_d;
    logic          wren_q, wren_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic ls_wins;
    assign ls_wins = bus.ls_req && !(bus.if_req && streak_q == SMAX);

    // Next-state: arbitration in IDLE, completion/timeout in ACCESS, single ack cycle in RESP
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        owner_d  = owner_q;
        wren_d   = wren_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (ls_wins) begin
                    state_d  = ACCESS;
                    owner_d  = 1'b1;
                    wren_d   = bus.ls_wren;
                    addr_d   = bus.ls_addr;
                    wdata_d  = bus.ls_wdata;
                    timer_d  = '0;
                    streak_d = bus.if_req ? streak_q + 1'b1 : '0;
                end else if (bus.if_req) begin
                    state_d  = ACCESS;
                    owner_d  = 1'b0;
                    wren_d   = 1'b0;
                    addr_d   = bus.if_addr;
                    wdata_d  = '0;
                    timer_d  = '0;
                    streak_d = '0;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                    rdata_d = wren_q ? 32'd0 : bus.mem_rdata;
                    err_d   = 1'b0;
                end else if (timer_q == TMAX) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything so all outputs read 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            timer_q  <= '0;
            owner_q  <= 1'b0;
            wren_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            owner_q  <= owner_d;
            wren_q   <= wren_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    logic in_access;
    logic in_resp;
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign bus.mem_req   = in_access;
    assign bus.mem_wren  = in_access && wren_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.if_ack    = in_resp && !owner_q;
    assign bus.ls_ack    = in_resp && owner_q;
    assign bus.bus_err   = in_resp && err_q;
    assign bus.if_rdata  = owner_q ? 32'd0 : rdata_q;
    assign bus.ls_rdata  = owner_q ? rdata_q : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven and outputs sampled on the falling edge.
// Expected values are hand-computed from the arbiter's cycle behaviour.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_LS_STREAK (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_wren   = 1'b0;
        bus.ls_addr   = '0;
        bus.ls_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        logic       own [6];
        logic       exp_own [6];
        int         n;
        int         cnt;
        int         ack_at [3];
        bit         done;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_acks", {30'd0, bus.if_ack, bus.ls_ack}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_owner", {31'd0, bus.owner}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: IF only
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge clk);
        chk("t1_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("t1_mem_wren", {31'd0, bus.mem_wren}, 32'd0);
        chk("t1_addr", bus.mem_addr, 32'h100);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00500093;
        @(negedge clk);
        chk("t1_if_ack", {31'd0, bus.if_ack}, 32'd1);
        chk("t1_if_rdata", bus.if_rdata, 32'h00500093);
        chk("t1_ls_ack", {31'd0, bus.ls_ack}, 32'd0);
        chk("t1_mem_req_off", {31'd0, bus.mem_req}, 32'd0);
        idle_inputs();
        @(negedge clk);

        // 2: LS store, memory ready after 3 cycles
        bus.ls_req   = 1'b1;
        bus.ls_wren  = 1'b1;
        bus.ls_addr  = 32'h2000;
        bus.ls_wdata = 32'hDEADBEEF;
        bus.mem_rdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t2_wren%0d", i), {31'd0, bus.mem_wren}, 32'd1);
        end
        chk("t2_addr", bus.mem_addr, 32'h2000);
        chk("t2_wdata", bus.mem_wdata, 32'hDEADBEEF);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("t2_ls_ack", {31'd0, bus.ls_ack}, 32'd1);
        chk("t2_ls_rdata", bus.ls_rdata, 32'd0);
        chk("t2_if_ack", {31'd0, bus.if_ack}, 32'd0);
        chk("t2_err", {31'd0, bus.bus_err}, 32'd0);
        chk("t2_wren_off", {31'd0, bus.mem_wren}, 32'd0);
        idle_inputs();
        @(negedge clk);

        // 3: both requesting, memory always ready
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h300;
        bus.ls_req    = 1'b1;
        bus.ls_addr   = 32'h4000;
        bus.mem_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                own[n] = bus.owner;
                n++;
            end
        end
        chk("t3_grants", n, 6);
        for (int i = 0; i < n; i++)
            chk($sformatf("t3_owner%0d", i), {31'd0, own[i]}, {31'd0, exp_own[i]});
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        repeat (4) @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // 4: timeout on a load
        bus.ls_req    = 1'b1;
        bus.ls_addr   = 32'h5000;
        bus.mem_rdata = 32'hFFFF0000;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_req) cnt++;
            if (bus.ls_ack) begin
                done = 1'b1;
                chk("t4_err", {31'd0, bus.bus_err}, 32'd1);
                chk("t4_ls_rdata", bus.ls_rdata, 32'd0);
                bus.ls_req = 1'b0;
            end
        end
        chk("t4_ack_seen", {31'd0, done}, 32'd1);
        chk("t4_req_cycles", cnt, 64);
        idle_inputs();
        @(negedge clk);
        chk("t4_err_clear", {31'd0, bus.bus_err}, 32'd0);

        // 5: reset in the middle of an access, then a stray mem_ready
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        @(negedge clk);
        chk("t5_in_access", {31'd0, bus.mem_req}, 32'd1);
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hAAAA5555;
        @(negedge clk);
        chk("t5_no_ack", {30'd0, bus.if_ack, bus.ls_ack}, 32'd0);
        chk("t5_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("t5_addr", bus.mem_addr, 32'd0);
        chk("t5_rdata", bus.if_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_stray_ack", {30'd0, bus.if_ack, bus.ls_ack}, 32'd0);
        chk("t5_stray_req", {31'd0, bus.mem_req}, 32'd0);
        idle_inputs();
        @(negedge clk);

        // 6: back-to-back fetches
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h700;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00000013;
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clk);
            if (bus.if_ack) begin
                ack_at[n] = c;
                n++;
                chk($sformatf("t6_rdata%0d", n), bus.if_rdata, 32'h13);
            end
        end
        bus.if_req = 1'b0;
        chk("t6_acks", n, 3);
        if (n == 3) begin
            chk("t6_gap0", ack_at[1] - ack_at[0], 3);
            chk("t6_gap1", ack_at[2] - ack_at[1], 3);
        end
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
